// File: rtl/twofish_pkg.sv
// twofish_pkg: Twofish constants, q0/q1 byte permutations and GF(2^8) helpers
// Latency: none (constants and pure combinational functions only)
// Backpressure: none
//
// The q0/q1 256-entry byte tables are expressed through their defining
// 4-bit t-tables. Each function call resolves to a fixed 256-entry lookup,
// which avoids maintaining 512 hand-typed bytes.
package twofish_pkg;

   // Field polynomials: MDS_POLY for the MDS multiply, RS_POLY for the
   // companion RS-matrix S-box-key stage that shares this package.
   localparam logic [8:0]  MDS_POLY = 9'h169;
   localparam logic [8:0]  RS_POLY  = 9'h14D;

   // Multiplying a byte by RHO replicates that byte into all four lanes.
   localparam logic [31:0] RHO      = 32'h01010101;

   // MDS matrix, indexed [row][column].
   localparam logic [7:0] MDS [4][4] = '{
      '{8'h01, 8'hEF, 8'h5B, 8'h5B},
      '{8'h5B, 8'hEF, 8'hEF, 8'h01},
      '{8'hEF, 8'h5B, 8'h01, 8'hEF},
      '{8'hEF, 8'h01, 8'hEF, 8'h5B}
   };

   // Key-schedule FSM states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC_A = 2'd1,
      ST_CALC_B = 2'd2,
      ST_FIN    = 2'd3
   } kgen_state_t;

   // Nibble t-tables that build q0.
   localparam logic [3:0] Q0_T0 [16] = '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2,
                                         4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4};
   localparam logic [3:0] Q0_T1 [16] = '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5,
                                         4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD};
   localparam logic [3:0] Q0_T2 [16] = '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0,
                                         4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1};
   localparam logic [3:0] Q0_T3 [16] = '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE,
                                         4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA};

   // Nibble t-tables that build q1.
   localparam logic [3:0] Q1_T0 [16] = '{4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE,
                                         4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5};
   localparam logic [3:0] Q1_T1 [16] = '{4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7,
                                         4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8};
   localparam logic [3:0] Q1_T2 [16] = '{4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA,
                                         4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF};
   localparam logic [3:0] Q1_T3 [16] = '{4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE,
                                         4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA};

   function automatic logic [3:0] ror4(input logic [3:0] v);
      return {v[0], v[3:1]};
   endfunction

   // Two mixing rounds over the nibble halves; sel picks the q1 t-tables.
   function automatic logic [7:0] q_perm(input logic sel, input logic [7:0] x);
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] ta;
      logic [3:0] tb;
      a  = x[7:4] ^ x[3:0];
      b  = x[7:4] ^ ror4(x[3:0]) ^ {x[4], 3'b000};
      ta = sel ? Q1_T0[a] : Q0_T0[a];
      tb = sel ? Q1_T1[b] : Q0_T1[b];
      a  = ta ^ tb;
      b  = ta ^ ror4(tb) ^ {ta[0], 3'b000};
      ta = sel ? Q1_T2[a] : Q0_T2[a];
      tb = sel ? Q1_T3[b] : Q0_T3[b];
      return {tb, ta};
   endfunction

   function automatic logic [7:0] q0(input logic [7:0] x);
      return q_perm(1'b0, x);
   endfunction

   function automatic logic [7:0] q1(input logic [7:0] x);
      return q_perm(1'b1, x);
   endfunction

   // GF(2^8) multiply modulo MDS_POLY. With one constant operand this
   // reduces to a small XOR network.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ MDS_POLY[7:0]) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   // The result's byte 0 is row 0 of the MDS times y, with y[0] the low byte.
   function automatic logic [31:0] mds_mul(input logic [3:0][7:0] yv);
      logic [31:0] z;
      logic [7:0]  acc;
      z = '0;
      for (int r = 0; r < 4; r++) begin
         acc = '0;
         for (int c = 0; c < 4; c++) acc = acc ^ gf_mul(MDS[r][c], yv[c]);
         z[8*r +: 8] = acc;
      end
      return z;
   endfunction

   // Little-endian key word j: m(4j) | m(4j+1)<<8 | ..., where m0 = key[127:120].
   function automatic logic [31:0] key_word(input logic [127:0] k, input int j);
      logic [31:0] w;
      w = k[127 - 32*j -: 32];
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/twofish_h2.sv
// twofish_h2: Twofish h-function for a two-word key list (L0, L1)
// Latency: purely combinational, 0 cycles
// Backpressure: none; the output follows the inputs
//
// Ports:
//   x   input  32  four input bytes x0..x3 (x0 = x[7:0])
//   l0  input  32  list word L0, applied last
//   l1  input  32  list word L1, applied first
//   y   output 32  MDS * (q-chain outputs)
module twofish_h2
   import twofish_pkg::*;
(
   input  logic [31:0] x,
   input  logic [31:0] l0,
   input  logic [31:0] l1,
   output logic [31:0] y
);

   logic [3:0][7:0] qb;

   // Each byte lane uses its own fixed q0/q1 ordering.
   assign qb[0] = q1(q0(q0(x[7:0])   ^ l1[7:0])   ^ l0[7:0]);
   assign qb[1] = q0(q0(q1(x[15:8])  ^ l1[15:8])  ^ l0[15:8]);
   assign qb[2] = q1(q1(q0(x[23:16]) ^ l1[23:16]) ^ l0[23:16]);
   assign qb[3] = q0(q1(q1(x[31:24]) ^ l1[31:24]) ^ l0[31:24]);

   assign y = mds_mul(qb);

endmodule

// File: rtl/twofish_subkey_gen.sv
// twofish_subkey_gen: expands a 128-bit Twofish key into subkeys K0..K39
// Latency: 41 cycles from start to done (2 cycles per subkey pair); reads take 1 cycle
// Backpressure: start is ignored unless the block is idle; there is no downstream stall
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset; clears the FSM, the outputs and the subkey array
//   start       one-cycle expansion request; sampled only in IDLE
//   key         128-bit cipher key; m0 = key[127:120]; captured with an accepted start
//   busy        high while subkey pairs are being computed
//   done        one-cycle pulse after the last pair is written
//   keys_valid  high from done until the next accepted start or reset
//   rd_addr     subkey index 0..39
//   rd_data     registered K[rd_addr]; 0 for rd_addr > 39
module twofish_subkey_gen
   import twofish_pkg::*;
#(
   parameter int NUM_SUBKEYS = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   output logic         busy,
   output logic         done,
   output logic         keys_valid,
   input  logic [5:0]   rd_addr,
   output logic [31:0]  rd_data
);

   localparam logic [4:0] LAST_PAIR = 5'(NUM_SUBKEYS / 2 - 1);

   kgen_state_t state;
   logic [4:0]  pair;
   logic [31:0] m_word [4];
   logic [31:0] a_reg;
   logic [31:0] kmem [NUM_SUBKEYS];

   logic        calc_b;
   logic [7:0]  h_byte;
   logic [31:0] h_x;
   logic [31:0] h_l0;
   logic [31:0] h_l1;
   logic [31:0] h_y;
   logic [31:0] b_rot;
   logic [31:0] sum_2b;
   logic [31:0] k_even;
   logic [31:0] k_odd;

   // The h datapath is shared between both phases. In CALC_A it uses the
   // even index 2i with (M0, M2). In CALC_B it uses the odd index 2i+1 with
   // (M1, M3), so the low bit of the index byte is the phase.
   assign calc_b = (state == ST_CALC_B);
   assign h_byte = {2'b00, pair, calc_b};
   assign h_x    = {24'd0, h_byte} * RHO;
   assign h_l0   = calc_b ? m_word[1] : m_word[0];
   assign h_l1   = calc_b ? m_word[3] : m_word[2];

   twofish_h2 u_h2 (
      .x  (h_x),
      .l0 (h_l0),
      .l1 (h_l1),
      .y  (h_y)
   );

   // Pseudo-Hadamard transform on A (registered) and ROL8(B) (live).
   assign b_rot  = {h_y[23:0], h_y[31:24]};
   assign k_even = a_reg + b_rot;
   assign sum_2b = a_reg + {b_rot[30:0], 1'b0};
   assign k_odd  = {sum_2b[22:0], sum_2b[31:23]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         pair       <= '0;
         a_reg      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         keys_valid <= 1'b0;
         for (int j = 0; j < 4; j++) m_word[j] <= '0;
         for (int n = 0; n < NUM_SUBKEYS; n++) kmem[n] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  for (int j = 0; j < 4; j++) m_word[j] <= key_word(key, j);
                  pair       <= '0;
                  keys_valid <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_CALC_A;
               end
            end
            ST_CALC_A: begin
               a_reg <= h_y;
               state <= ST_CALC_B;
            end
            ST_CALC_B: begin
               kmem[{pair, 1'b0}] <= k_even;
               kmem[{pair, 1'b1}] <= k_odd;
               if (pair == LAST_PAIR) begin
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  keys_valid <= 1'b1;
                  state      <= ST_FIN;
               end else begin
                  pair  <= pair + 5'd1;
                  state <= ST_CALC_A;
               end
            end
            ST_FIN: begin
               // One extra cycle holds off a new start until done has dropped.
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The read path samples the array before any same-edge write lands,
   // so a read that collides with a write returns the old entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_addr < 6'(NUM_SUBKEYS)) begin
         rd_data <= kmem[rd_addr];
      end else begin
         rd_data <= '0;
      end
   end

endmodule

// File: tb/tb_twofish_subkey_gen.sv
// tb_twofish_subkey_gen: scoreboard bench for twofish_subkey_gen against a reference key schedule
// Latency: n/a (testbench)
// Backpressure: n/a (testbench)
module tb_twofish_subkey_gen;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic [5:0]   rd_addr;
   logic [31:0]  rd_data;

   always #5 clk = ~clk;

   // Cycle n begins at the rising edge that sets cyc to n.
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   twofish_subkey_gen #(.NUM_SUBKEYS(40)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key        (key),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [127:0] key;
      logic [31:0]  done_cyc;
   } run_t;

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] exp;
   } rd_t;

   run_t run_q [$];
   rd_t  rd_q [$];
   rd_t  rd_pend [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   localparam logic [3:0] TT [2][4][16] = '{
      '{ '{4'h8,4'h1,4'h7,4'hD,4'h6,4'hF,4'h3,4'h2,4'h0,4'hB,4'h5,4'h9,4'hE,4'hC,4'hA,4'h4},
         '{4'hE,4'hC,4'hB,4'h8,4'h1,4'h2,4'h3,4'h5,4'hF,4'h4,4'hA,4'h6,4'h7,4'h0,4'h9,4'hD},
         '{4'hB,4'hA,4'h5,4'hE,4'h6,4'hD,4'h9,4'h0,4'hC,4'h8,4'hF,4'h3,4'h2,4'h4,4'h7,4'h1},
         '{4'hD,4'h7,4'hF,4'h4,4'h1,4'h2,4'h6,4'hE,4'h9,4'hB,4'h3,4'h0,4'h8,4'h5,4'hC,4'hA} },
      '{ '{4'h2,4'h8,4'hB,4'hD,4'hF,4'h7,4'h6,4'hE,4'h3,4'h1,4'h9,4'h4,4'h0,4'hA,4'hC,4'h5},
         '{4'h1,4'hE,4'h2,4'hB,4'h4,4'hC,4'h3,4'h7,4'h6,4'hD,4'hA,4'h5,4'hF,4'h9,4'h0,4'h8},
         '{4'h4,4'hC,4'h7,4'h5,4'h1,4'h6,4'h9,4'hA,4'h0,4'hE,4'hD,4'h8,4'h2,4'hB,4'h3,4'hF},
         '{4'hB,4'h9,4'h5,4'h1,4'hC,4'h3,4'hD,4'hE,4'h6,4'h4,4'h7,4'hF,4'h2,4'h0,4'h8,4'hA} }
   };
   // Per byte lane, the q permutations applied innermost first (0 = q0, 1 = q1).
   localparam int QS [4][3] = '{'{0,0,1}, '{1,0,0}, '{0,1,1}, '{1,1,0}};
   localparam int MDSB [4][4] = '{'{'h01,'hEF,'h5B,'h5B}, '{'h5B,'hEF,'hEF,'h01},
                                  '{'hEF,'h5B,'h01,'hEF}, '{'hEF,'h01,'hEF,'h5B}};

   function automatic logic [7:0] perm(input int s, input logic [7:0] x);
      logic [3:0] a, b, ta, tb;
      a = x[7:4];
      b = x[3:0];
      for (int r = 0; r < 2; r++) begin
         ta = a ^ b;
         tb = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
         a  = TT[s][2*r][ta];
         b  = TT[s][2*r+1][tb];
      end
      return {b, a};
   endfunction

   function automatic int gmul(input int a, input int b);
      int p = 0;
      int aa = a;
      for (int i = 0; i < 8; i++) begin
         if (((b >> i) & 1) != 0) p = p ^ aa;
         aa = aa << 1;
         if ((aa & 'h100) != 0) aa = aa ^ 'h169;
      end
      return p;
   endfunction

   function automatic logic [31:0] rol(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [31:0] ref_h(input logic [7:0] xb, input logic [31:0] l0, input logic [31:0] l1);
      int y [4];
      int acc;
      logic [7:0]  t;
      logic [31:0] z;
      z = 0;
      for (int b = 0; b < 4; b++) begin
         t = perm(QS[b][0], xb);
         t = perm(QS[b][1], t ^ l1[8*b +: 8]);
         t = perm(QS[b][2], t ^ l0[8*b +: 8]);
         y[b] = int'(t);
      end
      for (int r = 0; r < 4; r++) begin
         acc = 0;
         for (int c = 0; c < 4; c++) acc = acc ^ gmul(MDSB[r][c], y[c]);
         z[8*r +: 8] = acc[7:0];
      end
      return z;
   endfunction

   function automatic logic [31:0] ref_k(input logic [127:0] k, input int idx);
      logic [31:0] m [4];
      logic [31:0] a, b;
      logic [7:0]  byt;
      int i;
      for (int j = 0; j < 4; j++) begin
         m[j] = 0;
         for (int bb = 0; bb < 4; bb++) begin
            byt  = k[127 - 8*(4*j + bb) -: 8];
            m[j] = m[j] | ({24'd0, byt} << (8*bb));
         end
      end
      i = idx / 2;
      a = ref_h(8'(2*i), m[0], m[2]);
      b = rol(ref_h(8'(2*i + 1), m[1], m[3]), 8);
      if (idx % 2 == 0) return a + b;
      return rol(a + {b[30:0], 1'b0}, 9);
   endfunction

   // ---------------- monitor / read driver ----------------
   int   busy_cnt = 0;
   logic done_prev = 1'b0;

   initial begin
      run_t r;
      rd_t  x;
      rd_addr = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rd_pend.size() > 0) begin
            x = rd_pend.pop_front();
            check($sformatf("rd_data[%0d]", x.addr), rd_data, x.exp);
         end
         if (rst === 1'b1) busy_cnt = 0;
         else if (busy === 1'b1) busy_cnt++;
         if (done_prev === 1'b1) check("done_one_cycle", {31'd0, done}, 32'd0);
         done_prev = done;
         if (done === 1'b1) begin
            if (run_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1, required no done (cycle %0d)", cyc);
            end else begin
               r = run_q.pop_front();
               check("done_cycle", cyc, r.done_cyc);
               check("busy_cycles", busy_cnt, 32'd40);
               check("keys_valid_at_done", {31'd0, keys_valid}, 32'd1);
               for (int j = 0; j < 40; j++) rd_q.push_back('{addr: 6'(j), exp: ref_k(r.key, j)});
               rd_q.push_back('{addr: 6'd40, exp: 32'd0});
               rd_q.push_back('{addr: 6'd63, exp: 32'd0});
            end
            busy_cnt = 0;
         end
         if (rd_q.size() > 0) begin
            x = rd_q.pop_front();
            rd_addr = x.addr;
            rd_pend.push_back(x);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_start(input logic [127:0] k, input bit expect_run, output int unsigned t0);
      @(negedge clk);
      start = 1'b1;
      key   = k;
      t0    = cyc;
      if (expect_run) run_q.push_back('{key: k, done_cyc: cyc + 41});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_cyc(input int unsigned target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_idle(input int limit);
      int c = 0;
      while ((run_q.size() + rd_q.size() + rd_pend.size()) != 0 && c < limit) begin
         @(negedge clk);
         c++;
      end
      n_tests++;
      if (c >= limit) begin
         n_fail++;
         $display("FAIL wait_idle: got timeout after %0d cycles, required scoreboard drained", limit);
         run_q.delete();
         rd_q.delete();
         rd_pend.delete();
      end
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int unsigned t0;
      logic [127:0] k3;
      rst   = 1'b1;
      start = 1'b0;
      key   = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_keys_valid", {31'd0, keys_valid}, 32'd0);
      check("reset_rd_data", rd_data, 32'd0);
      rst = 1'b0;
      for (int a = 0; a < 64; a++) rd_q.push_back('{addr: 6'(a), exp: 32'd0});
      wait_idle(200);

      // Zero key, including the published first four subkeys
      do_start(128'h0, 1'b1, t0);
      wait_idle(300);
      rd_q.push_back('{addr: 6'd0, exp: 32'h52C54DDE});
      rd_q.push_back('{addr: 6'd1, exp: 32'h11F0626D});
      rd_q.push_back('{addr: 6'd2, exp: 32'h7CAC9D4A});
      rd_q.push_back('{addr: 6'd3, exp: 32'h4D1B4AAA});
      wait_idle(50);

      // Random keys
      for (int n = 0; n < 50; n++) begin
         do_start(rand_key(), 1'b1, t0);
         wait_idle(300);
      end

      // Starts while busy and in FIN are ignored; a start at T0+42 is taken
      do_start(rand_key(), 1'b1, t0);
      wait_cyc(t0 + 5);
      start = 1'b1;
      key   = rand_key();
      @(negedge clk);
      start = 1'b0;
      wait_cyc(t0 + 41);
      start = 1'b1;
      key   = rand_key();
      @(negedge clk);
      check("kv_before_restart", {31'd0, keys_valid}, 32'd1);
      k3  = rand_key();
      key = k3;
      run_q.push_back('{key: k3, done_cyc: cyc + 41});
      @(negedge clk);
      start = 1'b0;
      check("kv_after_restart", {31'd0, keys_valid}, 32'd0);
      check("busy_after_restart", {31'd0, busy}, 32'd1);
      wait_idle(300);

      // Reset in the middle of an expansion
      do_start(rand_key(), 1'b0, t0);
      wait_cyc(t0 + 20);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_keys_valid", {31'd0, keys_valid}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      for (int a = 0; a < 64; a++) rd_q.push_back('{addr: 6'(a), exp: 32'd0});
      wait_idle(200);
      do_start(rand_key(), 1'b1, t0);
      wait_idle(300);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/twofish_subkey_gen.md
# twofish_subkey_gen

Sequential Twofish key-schedule stage for 128-bit keys. It expands the cipher key into the 40 round subkeys K0..K39 and holds them in an internal register file for the decryption round engine to read. It works alongside the RS-matrix S-box-key stage: both take the same 128-bit key, and this block produces the whitening and round subkeys rather than S0/S1. It uses one time-multiplexed h-function datapath, 2 cycles per subkey pair.

## Interface
Parameters:
- NUM_SUBKEYS, 40: number of subkeys generated and stored. Fixed for 128-bit keys.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  single-cycle request to expand `key`; sampled only in IDLE.
- key  input  128  cipher key; byte m0 = key[127:120] … m15 = key[7:0]; sampled with an accepted `start`.
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse when all 40 subkeys are written.
- keys_valid  output  1  high from `done` until the next accepted `start` or `rst`.
- rd_addr  input  6  subkey index for reading, 0..39.
- rd_data  output  32  registered read data; K[rd_addr], or 0 if rd_addr > 39.

## Operation
- Words are formed little-endian: Mj = m(4j) | m(4j+1)<<8 | m(4j+2)<<16 | m(4j+3)<<24, for j = 0..3.
- Me = (M0, M2) and Mo = (M1, M3). ρ = 32'h01010101.
- For pair i = 0..19:
  - A = h(2i·ρ, Me); B = ROL8(h((2i+1)·ρ, Mo)).
  - K[2i] = A + B mod 2^32; K[2i+1] = ROL9(A + 2B mod 2^32).
- h with k = 2, input bytes x0..x3, list (L0, L1):
  - y0 = q1[q0[q0[x0]^L1.b0]^L0.b0]
  - y1 = q0[q0[q1[x1]^L1.b1]^L0.b1]
  - y2 = q1[q1[q0[x2]^L1.b2]^L0.b2]
  - y3 = q0[q1[q1[x3]^L1.b3]^L0.b3]
  - Output = MDS·y over GF(2^8), polynomial 0x169.
- FSM states:
  - IDLE: on `start`, latch key, clear i and keys_valid, go to CALC_A.
  - CALC_A: h(2i·ρ, Me) → A register; go to CALC_B.
  - CALC_B: h((2i+1)·ρ, Mo) → B; write K[2i] and K[2i+1]. If i = 19 go to FIN, else i++ and go to CALC_A.
  - FIN: pulse done, set keys_valid; go to IDLE.
- `start` while busy or in FIN is ignored. The key register is not updated.
- Reads are allowed at any time and return the current array contents. Entries may be stale while busy; consumers wait for keys_valid.

## Timing
- Reset values: busy=0, done=0, keys_valid=0, rd_data=0, FSM=IDLE, i=0, all 40 array entries = 0.
- `start` accepted at edge T0. busy is high in cycles T0+1 … T0+40 (20 pairs × 2 cycles).
- Pair i is written at the end of cycle T0+2i+2.
- done and keys_valid rise in cycle T0+41; done falls in T0+42.
- A new `start` is accepted no earlier than cycle T0+42.
- Read latency: 1 cycle (rd_addr at edge n → rd_data valid after edge n+1).
- A read and a write to the same entry in one cycle returns the old value.
- `rst` mid-expansion: aborts next edge; all outputs and the array return to reset values.
- `rst` and `start` together: rst wins, start is dropped.

## Structure
- Package `twofish_pkg` holds:
  - q0/q1 256-entry byte tables;
  - the MDS matrix constants;
  - GF polynomials MDS_POLY = 9'h169 and RS_POLY = 9'h14D;
  - RHO = 32'h01010101;
  - an FSM state enum.
- One sub-module, `twofish_h2`: combinational h-function for k = 2 (32-bit x, two 32-bit L words → 32-bit result). A single instance is shared by CALC_A and CALC_B.
- Top level holds the FSM, pair counter, A register, key registers, 40×32 array and read register.

## Test plan
- Reset: assert rst 2 cycles → busy/done/keys_valid = 0; rd_data = 0 for every address.
- Zero key: start, key = 128'h0 → done at T0+41; K0 = 32'h52C54DDE, K1 = 32'h11F0626D, K2 = 32'h7CAC9D4A, K3 = 32'h4D1B4AAA; all 40 entries match the golden model.
- Random keys (≥ 50): all K0..K39 equal the software reference; busy is exactly 40 cycles each time.
- start pulsed at T0+5 and T0+41 → ignored; K values and done timing unchanged. A start at T0+42 begins a new run and keys_valid drops at T0+43.
- rst at T0+20 → next cycle busy = 0, keys_valid = 0, array all zero. A fresh start then completes normally.
- rd_addr = 40 and 63 → rd_data = 0. Back-to-back rd_addr 0,1,…,39 → rd_data streams K0…K39 at 1-cycle latency.
